box_queue_sequencer: RTL and testbench

- Sits directly upstream of the box drawer.
- Accepts bounding boxes from the star-detection stage over a valid/ready handshake and buffers them in a small FIFO.
- Validates and clips each box, then feeds boxes to the drawer one at a time. For each box it presents stable coordinates, pulses goDraw, and waits for doneDraw before issuing the next box.
- Rejected boxes and drawer hangs are reported through status outputs.

---
 rtl/box_queue_sequencer_if.sv | 33 +++
 rtl/box_queue_sequencer.sv | 157 +++++++++++++++
 tb/tb_box_queue_sequencer.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/box_queue_sequencer_if.sv
// Box handshake bundle: upstream valid/ready box bus plus the drawer
// go/done bus with its registered coordinates.
interface box_queue_sequencer_if #(
  parameter int XSZ = 8,
  parameter int YSZ = 7
);
  // upstream box bus
  logic           boxValid;
  logic           boxReady;
  logic [XSZ-1:0] inXLeft;
  logic [XSZ-1:0] inXRight;
  logic [YSZ-1:0] inYTop;
  logic [YSZ-1:0] inYBottom;
  // drawer bus
  logic           goDraw;
  logic           doneDraw;
  logic [XSZ-1:0] xLeft;
  logic [XSZ-1:0] xRight;
  logic [YSZ-1:0] yTop;
  logic [YSZ-1:0] yBottom;

  // sequencer side
  modport slave (
    input  boxValid, inXLeft, inXRight, inYTop, inYBottom, doneDraw,
    output boxReady, goDraw, xLeft, xRight, yTop, yBottom
  );

  // environment side: box source and drawer
  modport master (
    output boxValid, inXLeft, inXRight, inYTop, inYBottom, doneDraw,
    input  boxReady, goDraw, xLeft, xRight, yTop, yBottom
  );
endinterface

// File: rtl/box_queue_sequencer.sv
// Box queue sequencer: validates and clips incoming boxes, queues them in a
// small FIFO and hands them to the drawer one at a time (go/done handshake
// with a timeout watchdog).
module box_queue_sequencer #(
  parameter int XSZ     = 8,
  parameter int YSZ     = 7,
  parameter int DEPTH   = 4,
  parameter int XMAX    = 159,
  parameter int YMAX    = 119,
  parameter int TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  box_queue_sequencer_if.slave  bus,
  output logic                  busy,
  output logic [7:0]            dropCount,
  output logic                  timeoutErr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [XSZ-1:0] XLIM = XSZ'(XMAX);
  localparam logic [YSZ-1:0] YLIM = YSZ'(YMAX);
  localparam logic [AW:0]    FULLCNT = (AW+1)'(DEPTH);
  localparam logic [CW-1:0]  LASTCNT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, GO, WAIT} state_t;

  state_t state, stateNext;

  logic [XSZ-1:0] memXL [DEPTH];
  logic [XSZ-1:0] memXR [DEPTH];
  logic [YSZ-1:0] memYT [DEPTH];
  logic [YSZ-1:0] memYB [DEPTH];

  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0]   count;
  logic [CW-1:0] waitCnt;

  logic full, empty;
  logic rejectBox, handshake, push, drop, pop;
  logic goNow, setTimeout;
  logic [XSZ-1:0] clipXR;
  logic [YSZ-1:0] clipYB;

  // Validation and clipping of the box currently on the input bus
  always_comb begin
    rejectBox = (bus.inXLeft > bus.inXRight) || (bus.inYTop > bus.inYBottom) ||
                (bus.inYTop == '0) || (bus.inXLeft > XLIM) || (bus.inYTop > YLIM);
    clipXR    = (bus.inXRight  > XLIM) ? XLIM : bus.inXRight;
    clipYB    = (bus.inYBottom > YLIM) ? YLIM : bus.inYBottom;
  end

  // FIFO status and transfer strobes
  always_comb begin
    full         = (count == FULLCNT);
    empty        = (count == '0);
    bus.boxReady = !full;
    handshake    = bus.boxValid && !full;
    push         = handshake && !rejectBox;
    drop         = handshake && rejectBox;
    pop          = (state == LOAD);
    busy         = !empty || (state != IDLE);
  end

  // FIFO storage; entries need no reset since pointers/count gate their use
  always_ff @(posedge clk) begin
    if (push) begin
      memXL[wrPtr] <= bus.inXLeft;
      memXR[wrPtr] <= clipXR;
      memYT[wrPtr] <= bus.inYTop;
      memYB[wrPtr] <= clipYB;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sequencer state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Sequencer next state and go pulse; done wins over a same-cycle timeout
  always_comb begin
    stateNext  = state;
    goNow      = 1'b0;
    setTimeout = 1'b0;
    case (state)
      IDLE: if (!empty) stateNext = LOAD;
      LOAD: stateNext = GO;
      GO: begin
        goNow     = 1'b1;
        stateNext = WAIT;
      end
      WAIT: begin
        if (bus.doneDraw) begin
          stateNext = IDLE;
        end else if (waitCnt == LASTCNT) begin
          setTimeout = 1'b1;
          stateNext  = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
    bus.goDraw = goNow;
  end

  // Drawer wait counter: cleared in GO, counts every WAIT cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               waitCnt <= '0;
    else if (state == GO)    waitCnt <= '0;
    else if (state == WAIT)  waitCnt <= waitCnt + 1'b1;
  end

  // Coordinate registers, loaded from the FIFO head at the end of LOAD
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.xLeft   <= '0;
      bus.xRight  <= '0;
      bus.yTop    <= '0;
      bus.yBottom <= '0;
    end else if (pop) begin
      bus.xLeft   <= memXL[rdPtr];
      bus.xRight  <= memXR[rdPtr];
      bus.yTop    <= memYT[rdPtr];
      bus.yBottom <= memYB[rdPtr];
    end
  end

  // Status: saturating reject counter and sticky timeout flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dropCount  <= '0;
      timeoutErr <= 1'b0;
    end else begin
      if (drop && (dropCount != '1)) dropCount <= dropCount + 1'b1;
      if (setTimeout)                timeoutErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_box_queue_sequencer.sv
// Directed self-checking bench for box_queue_sequencer.
module tb_box_queue_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       busy;
  logic [7:0] dropCount;
  logic       timeoutErr;
  int         checks = 0;
  int         errors = 0;

  box_queue_sequencer_if #(.XSZ(8), .YSZ(7)) bus ();

  box_queue_sequencer #(
    .XSZ(8), .YSZ(7), .DEPTH(4), .XMAX(159), .YMAX(119), .TIMEOUT(4096)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .busy(busy),
    .dropCount(dropCount),
    .timeoutErr(timeoutErr)
  );

  always #5 clk = ~clk;

  function automatic logic [29:0] pk(input int a, input int b, input int c, input int d);
    return {8'(a), 8'(b), 7'(c), 7'(d)};
  endfunction

  function automatic logic [29:0] coords();
    return {bus.xLeft, bus.xRight, bus.yTop, bus.yBottom};
  endfunction

  // One clock; the box source drops boxValid once its handshake completed.
  task automatic step();
    logic hs;
    hs = bus.boxValid && bus.boxReady;
    @(posedge clk);
    #1;
    if (hs) bus.boxValid = 1'b0;
  endtask

  task automatic setBox(input int xl, input int xr, input int yt, input int yb);
    bus.inXLeft   = 8'(xl);
    bus.inXRight  = 8'(xr);
    bus.inYTop    = 7'(yt);
    bus.inYBottom = 7'(yb);
    bus.boxValid  = 1'b1;
  endtask

  task automatic pushBox(input int xl, input int xr, input int yt, input int yb, input string name);
    int n;
    setBox(xl, xr, yt, yb);
    n = 0;
    while (bus.boxValid && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (bus.boxValid !== 1'b0) begin
      errors++;
      $display("FAIL push_%s: handshake not completed, boxValid=%b required 0", name, bus.boxValid);
      bus.boxValid = 1'b0;
    end
  endtask

  task automatic waitGo(input string name, output int n);
    n = 0;
    while (bus.goDraw !== 1'b1 && n < 8200) begin
      step();
      n++;
    end
    checks++;
    if (bus.goDraw !== 1'b1) begin
      errors++;
      $display("FAIL waitgo_%s: goDraw=%b required 1 within budget", name, bus.goDraw);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.boxValid = 1'b0;
    bus.doneDraw = 1'b0;
    setBox(0, 0, 0, 0);
    bus.boxValid = 1'b0;
    step();
    step();
    checks++;
    if ({bus.goDraw, busy, timeoutErr} !== 3'b000) begin
      errors++;
      $display("FAIL rst_flags: go/busy/tmo=%b required 000", {bus.goDraw, busy, timeoutErr});
    end
    checks++;
    if (dropCount !== 8'd0) begin
      errors++;
      $display("FAIL rst_drop: dropCount=%0d required 0", dropCount);
    end
    checks++;
    if (coords() !== 30'd0) begin
      errors++;
      $display("FAIL rst_coords: coords=%h required 0", coords());
    end
    checks++;
    if (bus.boxReady !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready: boxReady=%b required 1", bus.boxReady);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    int bad;
    doReset();
    setBox(10, 20, 5, 15);
    checks++;
    if (bus.boxReady !== 1'b1) begin
      errors++;
      $display("FAIL single_ready: boxReady=%b required 1", bus.boxReady);
    end
    step();                                   // k+1
    checks++;
    if (bus.goDraw !== 1'b0) begin
      errors++;
      $display("FAIL single_k1: goDraw=%b required 0", bus.goDraw);
    end
    step();                                   // k+2
    checks++;
    if (bus.goDraw !== 1'b0) begin
      errors++;
      $display("FAIL single_k2: goDraw=%b required 0", bus.goDraw);
    end
    step();                                   // k+3
    checks++;
    if (bus.goDraw !== 1'b1) begin
      errors++;
      $display("FAIL single_k3: goDraw=%b required 1", bus.goDraw);
    end
    checks++;
    if (coords() !== pk(10, 20, 5, 15)) begin
      errors++;
      $display("FAIL single_coords: coords=%h required %h", coords(), pk(10, 20, 5, 15));
    end
    bad = 0;
    for (int i = 1; i < 40; i++) begin
      step();
      if (bus.goDraw !== 1'b0 || coords() !== pk(10, 20, 5, 15) || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL single_hold: %0d bad WAIT cycles required 0", bad);
    end
    step();                                   // g+40
    bus.doneDraw = 1'b1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy_done: busy=%b required 1", busy);
    end
    step();
    bus.doneDraw = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_after: busy=%b required 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [29:0] exps [5];
    int n;
    exps[0] = pk(10, 20, 1, 5);
    exps[1] = pk(20, 40, 2, 6);
    exps[2] = pk(30, 60, 3, 7);
    exps[3] = pk(40, 80, 4, 8);
    exps[4] = pk(50, 100, 5, 9);
    doReset();
    pushBox(1, 2, 1, 2, "b2b_lead");
    waitGo("b2b_lead", n);
    step();                                   // drawer stalled in WAIT
    for (int i = 0; i < 4; i++)
      pushBox((i + 1) * 10, (i + 1) * 20, i + 1, i + 5, "b2b_fill");
    checks++;
    if (bus.boxReady !== 1'b0) begin
      errors++;
      $display("FAIL b2b_full: boxReady=%b required 0", bus.boxReady);
    end
    setBox(50, 100, 5, 9);
    for (int i = 0; i < 5; i++) begin
      bus.doneDraw = 1'b1;
      step();
      bus.doneDraw = 1'b0;
      n = 1;
      while (bus.goDraw !== 1'b1 && n < 8) begin
        step();
        n++;
      end
      checks++;
      if (bus.goDraw !== 1'b1 || n != 3) begin
        errors++;
        $display("FAIL b2b_gap%0d: goDraw=%b after %0d cycles required 1 after 3", i, bus.goDraw, n);
      end
      checks++;
      if (coords() !== exps[i]) begin
        errors++;
        $display("FAIL b2b_order%0d: coords=%h required %h", i, coords(), exps[i]);
      end
      step();
      checks++;
      if (bus.goDraw !== 1'b0) begin
        errors++;
        $display("FAIL b2b_pulse%0d: goDraw=%b required 0", i, bus.goDraw);
      end
    end
    bus.doneDraw = 1'b1;
    step();
    bus.doneDraw = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_reject();
    int gos;
    doReset();
    pushBox(30, 20, 5, 9, "rej_x");
    pushBox(1, 2, 0, 3, "rej_y0");
    pushBox(200, 210, 1, 2, "rej_xmax");
    checks++;
    if (dropCount !== 8'd3) begin
      errors++;
      $display("FAIL rej_count3: dropCount=%0d required 3", dropCount);
    end
    gos = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.goDraw !== 1'b0) gos++;
    end
    checks++;
    if (gos != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rej_nodraw: goDraw cycles=%0d busy=%b required 0/0", gos, busy);
    end
    pushBox(1, 2, 120, 125, "rej_ymax");
    pushBox(1, 2, 9, 5, "rej_yorder");
    checks++;
    if (dropCount !== 8'd5) begin
      errors++;
      $display("FAIL rej_count5: dropCount=%0d required 5", dropCount);
    end
    for (int i = 0; i < 255; i++) begin
      setBox(30, 20, 5, 9);
      step();
    end
    bus.boxValid = 1'b0;
    checks++;
    if (dropCount !== 8'd255) begin
      errors++;
      $display("FAIL rej_saturate: dropCount=%0d required 255", dropCount);
    end
  endtask

  task automatic test_clip();
    int n;
    doReset();
    pushBox(150, 170, 100, 127, "clip");
    waitGo("clip", n);
    checks++;
    if (coords() !== pk(150, 159, 100, 119)) begin
      errors++;
      $display("FAIL clip_coords: coords=%h required %h", coords(), pk(150, 159, 100, 119));
    end
    step();
    bus.doneDraw = 1'b1;
    step();
    bus.doneDraw = 1'b0;
    pushBox(159, 200, 119, 127, "clip_edge");
    waitGo("clip_edge", n);
    checks++;
    if (coords() !== pk(159, 159, 119, 119)) begin
      errors++;
      $display("FAIL clip_edge: coords=%h required %h", coords(), pk(159, 159, 119, 119));
    end
    checks++;
    if (dropCount !== 8'd0) begin
      errors++;
      $display("FAIL clip_nodrop: dropCount=%0d required 0", dropCount);
    end
    step();
    bus.doneDraw = 1'b1;
    step();
    bus.doneDraw = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    doReset();
    pushBox(11, 22, 3, 4, "tmo_a");
    pushBox(33, 44, 5, 6, "tmo_b");
    waitGo("tmo_a", n);
    for (int i = 0; i < 4096; i++) step();   // g+4096: final WAIT cycle
    checks++;
    if (timeoutErr !== 1'b0) begin
      errors++;
      $display("FAIL tmo_early: timeoutErr=%b required 0", timeoutErr);
    end
    step();                                   // g+4097: back in IDLE
    checks++;
    if (timeoutErr !== 1'b1) begin
      errors++;
      $display("FAIL tmo_set: timeoutErr=%b required 1", timeoutErr);
    end
    waitGo("tmo_b", n);
    checks++;
    if (n != 2 || coords() !== pk(33, 44, 5, 6)) begin
      errors++;
      $display("FAIL tmo_next: go after %0d coords=%h required 2 %h", n, coords(), pk(33, 44, 5, 6));
    end
    step();
    bus.doneDraw = 1'b1;
    step();
    bus.doneDraw = 1'b0;
    checks++;
    if (timeoutErr !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL tmo_sticky: timeoutErr=%b busy=%b required 1/0", timeoutErr, busy);
    end
    doReset();
    checks++;
    if (timeoutErr !== 1'b0) begin
      errors++;
      $display("FAIL tmo_rstclr: timeoutErr=%b required 0", timeoutErr);
    end
    pushBox(12, 13, 1, 2, "tmo_c");
    waitGo("tmo_c", n);
    for (int i = 0; i < 4096; i++) step();
    bus.doneDraw = 1'b1;                      // done on the timeout cycle
    step();
    bus.doneDraw = 1'b0;
    checks++;
    if (timeoutErr !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL tmo_tie: timeoutErr=%b busy=%b required 0/0", timeoutErr, busy);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int gos;
    doReset();
    pushBox(30, 20, 5, 9, "mid_rej");
    pushBox(10, 20, 5, 15, "mid_a");
    pushBox(21, 31, 6, 16, "mid_b");
    pushBox(22, 32, 7, 17, "mid_c");
    waitGo("mid_a", n);
    step();
    step();
    checks++;
    if (bus.xLeft !== 8'd10 || busy !== 1'b1 || dropCount !== 8'd1) begin
      errors++;
      $display("FAIL mid_pre: xLeft=%0d busy=%b drop=%0d required 10/1/1", bus.xLeft, busy, dropCount);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (coords() !== 30'd0 || {bus.goDraw, busy, timeoutErr} !== 3'b000 || dropCount !== 8'd0) begin
      errors++;
      $display("FAIL mid_async: coords=%h flags=%b drop=%0d required 0", coords(), {bus.goDraw, busy, timeoutErr}, dropCount);
    end
    checks++;
    if (bus.boxReady !== 1'b1) begin
      errors++;
      $display("FAIL mid_ready: boxReady=%b required 1", bus.boxReady);
    end
    step();
    step();
    reset = 1'b0;
    gos = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.goDraw !== 1'b0 || busy !== 1'b0) gos++;
    end
    checks++;
    if (gos != 0) begin
      errors++;
      $display("FAIL mid_quiet: %0d active cycles required 0", gos);
    end
    pushBox(7, 9, 3, 4, "mid_d");
    waitGo("mid_d", n);
    checks++;
    if (n != 2 || coords() !== pk(7, 9, 3, 4)) begin
      errors++;
      $display("FAIL mid_new: go after %0d coords=%h required 2 %h", n, coords(), pk(7, 9, 3, 4));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reject();
    test_clip();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
